// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the request, response and ALU-side signals of alu_arbiter.
//   req0_*/req1_* : valid/ready request channels carrying op, a, b
//   rsp0_*/rsp1_* : valid/ready response channels carrying result
//   alu_*         : opcode/operands driven to the ALU, result returned from it
// Modports:
//   slave  : the arbiter's view
//   master : the view of the requesters plus the ALU datapath
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;

    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
        output alu_op, alu_a, alu_b
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
        input  alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters. One request is granted at a time,
// its op/a/b are registered onto the ALU inputs, the result is captured after
// ALU_LATENCY further edges and returned on the owner's response channel.
//
// Parameters:
//   WIDTH       : operand/result width
//   ALU_LATENCY : edges from ALU inputs valid to ALU result valid (0..7)
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset (aborts any operation in flight)
//   bus : alu_arbiter_if.slave (request, response and ALU signals)
//
// Build option:
//   ALU_ARBITER_FIXED_PRIO_EN defined   -> req0 always wins a tie
//   ALU_ARBITER_FIXED_PRIO_EN undefined -> round-robin tie-break via `last`
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH       = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    alu_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_C = 3'(ALU_LATENCY);

    state_t           state_q;
    logic [2:0]       cnt_q;
    logic             owner_q;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
    logic             last_q;
`endif
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic [WIDTH-1:0] rsp0_result_q;
    logic [WIDTH-1:0] rsp1_result_q;

    logic             grant_s;
    logic             req0_ready_s;
    logic             req1_ready_s;
    logic             accept_s;
    logic             rsp_hs_s;

    // Grant selection: a lone valid wins; a tie goes to the requester that was not served last.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            grant_s = 1'b0;
`else
            grant_s = ~last_q;
`endif
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Request ready: only in IDLE and only for the granted, valid requester.
    always_comb begin
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        if (state_q == IDLE) begin
            req0_ready_s = bus.req0_valid && !grant_s;
            req1_ready_s = bus.req1_valid &&  grant_s;
        end else begin
            req0_ready_s = 1'b0;
            req1_ready_s = 1'b0;
        end
    end

    assign accept_s = req0_ready_s || req1_ready_s;

    // Response handshake on the owner's channel; a ready without valid is ignored.
    always_comb begin
        rsp_hs_s = 1'b0;
        if (owner_q) begin
            rsp_hs_s = rsp1_valid_q && bus.rsp1_ready;
        end else begin
            rsp_hs_s = rsp0_valid_q && bus.rsp0_ready;
        end
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            owner_q       <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
            last_q        <= 1'b1;   // req0 wins the first tie
`endif
            alu_op_q      <= 3'd0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        alu_op_q <= grant_s ? bus.req1_op : bus.req0_op;
                        alu_a_q  <= grant_s ? bus.req1_a  : bus.req0_a;
                        alu_b_q  <= grant_s ? bus.req1_b  : bus.req0_b;
                        cnt_q    <= LAT_C;
                        owner_q  <= grant_s;
                        state_q  <= WAIT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                WAIT: begin
                    // Counter reaches zero on the edge where the ALU result is valid.
                    if (cnt_q == 3'd0) begin
                        if (owner_q) begin
                            rsp1_result_q <= bus.alu_result;
                            rsp1_valid_q  <= 1'b1;
                        end else begin
                            rsp0_result_q <= bus.alu_result;
                            rsp0_valid_q  <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs_s) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
                        last_q       <= owner_q;
`endif
                        state_q      <= IDLE;
                    end else begin
                        state_q      <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready  = req0_ready_s;
    assign bus.req1_ready  = req1_ready_s;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp0_result = rsp0_result_q;
    assign bus.rsp1_result = rsp1_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter. Four instances: ALU_LATENCY = 1 (main),
// 3 (reset mid-operation), 0 and 7 (latency sweep). Each instance sees a
// combinational ALU model on its registered alu_* outputs:
//   op 1 : a + b    op 2 : a - b    op 5 : a & b    others : a ^ b
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    logic clk;
    logic rst;
    logic rst3;
    int   compared;
    int   mismatched;

    alu_arbiter_if #(.WIDTH(16)) if1 ();
    alu_arbiter_if #(.WIDTH(16)) if3 ();
    alu_arbiter_if #(.WIDTH(16)) if0 ();
    alu_arbiter_if #(.WIDTH(16)) if7 ();

    alu_arbiter #(.WIDTH(16), .ALU_LATENCY(1)) u_dut  (.clk(clk), .rst(rst),  .bus(if1));
    alu_arbiter #(.WIDTH(16), .ALU_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(if3));
    alu_arbiter #(.WIDTH(16), .ALU_LATENCY(0)) u_dut0 (.clk(clk), .rst(rst),  .bus(if0));
    alu_arbiter #(.WIDTH(16), .ALU_LATENCY(7)) u_dut7 (.clk(clk), .rst(rst),  .bus(if7));

    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd1:    alu_model = a + b;
            3'd2:    alu_model = a - b;
            3'd5:    alu_model = a & b;
            default: alu_model = a ^ b;
        endcase
    endfunction

    assign if1.alu_result = alu_model(if1.alu_op, if1.alu_a, if1.alu_b);
    assign if3.alu_result = alu_model(if3.alu_op, if3.alu_a, if3.alu_b);
    assign if0.alu_result = alu_model(if0.alu_op, if0.alu_a, if0.alu_b);
    assign if7.alu_result = alu_model(if7.alu_op, if7.alu_a, if7.alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic init_inputs();
        if1.req0_valid = 1'b0; if1.req0_op = 3'd0; if1.req0_a = 16'h0000; if1.req0_b = 16'h0000;
        if1.req1_valid = 1'b0; if1.req1_op = 3'd0; if1.req1_a = 16'h0000; if1.req1_b = 16'h0000;
        if1.rsp0_ready = 1'b0; if1.rsp1_ready = 1'b0;
        if3.req0_valid = 1'b0; if3.req0_op = 3'd0; if3.req0_a = 16'h0000; if3.req0_b = 16'h0000;
        if3.req1_valid = 1'b0; if3.req1_op = 3'd0; if3.req1_a = 16'h0000; if3.req1_b = 16'h0000;
        if3.rsp0_ready = 1'b0; if3.rsp1_ready = 1'b0;
        if0.req0_valid = 1'b0; if0.req0_op = 3'd0; if0.req0_a = 16'h0000; if0.req0_b = 16'h0000;
        if0.req1_valid = 1'b0; if0.req1_op = 3'd0; if0.req1_a = 16'h0000; if0.req1_b = 16'h0000;
        if0.rsp0_ready = 1'b0; if0.rsp1_ready = 1'b0;
        if7.req0_valid = 1'b0; if7.req0_op = 3'd0; if7.req0_a = 16'h0000; if7.req0_b = 16'h0000;
        if7.req1_valid = 1'b0; if7.req1_op = 3'd0; if7.req1_a = 16'h0000; if7.req1_b = 16'h0000;
        if7.rsp0_ready = 1'b0; if7.rsp1_ready = 1'b0;
    endtask

    // Ends on a falling edge with reset released; the next cycle is cycle 0.
    task automatic do_reset();
        @(negedge clk); rst = 1'b1; rst3 = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (if1.req0_ready !== 1'b0 || if1.req1_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b%b want 00", if1.req0_ready, if1.req1_ready); end
        compared++; if (if1.rsp0_valid !== 1'b0 || if1.rsp1_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid: got %b%b want 00", if1.rsp0_valid, if1.rsp1_valid); end
        compared++; if (if1.alu_op !== 3'd0 || if1.alu_a !== 16'h0000 || if1.alu_b !== 16'h0000) begin mismatched++; $display("FAIL reset_alu: got %h/%h/%h want 0/0000/0000", if1.alu_op, if1.alu_a, if1.alu_b); end
        compared++; if (if1.rsp0_result !== 16'h0000 || if1.rsp1_result !== 16'h0000) begin mismatched++; $display("FAIL reset_result: got %h/%h want 0000/0000", if1.rsp0_result, if1.rsp1_result); end
    endtask

    task automatic test_single_op();
        if1.req0_valid = 1'b1; if1.req0_op = 3'd1; if1.req0_a = 16'h0005; if1.req0_b = 16'h0003; if1.rsp0_ready = 1'b1;
        #1;
        compared++; if (if1.req0_ready !== 1'b1 || if1.req1_ready !== 1'b0) begin mismatched++; $display("FAIL single_ready_c0: got %b%b want 10", if1.req0_ready, if1.req1_ready); end
        @(negedge clk); // cycle 1
        compared++; if (if1.alu_op !== 3'd1 || if1.alu_a !== 16'h0005 || if1.alu_b !== 16'h0003) begin mismatched++; $display("FAIL single_alu_c1: got %h/%h/%h want 1/0005/0003", if1.alu_op, if1.alu_a, if1.alu_b); end
        compared++; if (if1.req0_ready !== 1'b0 || if1.rsp0_valid !== 1'b0) begin mismatched++; $display("FAIL single_c1: ready %b valid %b want 0 0", if1.req0_ready, if1.rsp0_valid); end
        @(negedge clk); // cycle 2
        compared++; if (if1.req0_ready !== 1'b0 || if1.rsp0_valid !== 1'b0) begin mismatched++; $display("FAIL single_c2: ready %b valid %b want 0 0", if1.req0_ready, if1.rsp0_valid); end
        @(negedge clk); // cycle 3
        compared++; if (if1.rsp0_valid !== 1'b1 || if1.rsp0_result !== 16'h0008) begin mismatched++; $display("FAIL single_rsp_c3: valid %b result %h want 1 0008", if1.rsp0_valid, if1.rsp0_result); end
        compared++; if (if1.req0_ready !== 1'b0) begin mismatched++; $display("FAIL single_ready_c3: got %b want 0", if1.req0_ready); end
        if1.req0_valid = 1'b0;
        @(negedge clk); // cycle 4
        compared++; if (if1.rsp0_valid !== 1'b0 || if1.rsp0_result !== 16'h0008) begin mismatched++; $display("FAIL single_hold_c4: valid %b result %h want 0 0008", if1.rsp0_valid, if1.rsp0_result); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        if1.req0_valid = 1'b1; if1.req0_op = 3'd2; if1.req0_a = 16'h0010; if1.req0_b = 16'h0004;
        if1.req1_valid = 1'b1; if1.req1_op = 3'd5; if1.req1_a = 16'h00F0; if1.req1_b = 16'h0033;
        if1.rsp0_ready = 1'b1; if1.rsp1_ready = 1'b1;
        #1;
        compared++; if (if1.req0_ready !== 1'b1 || if1.req1_ready !== 1'b0) begin mismatched++; $display("FAIL sim_first_grant: got %b%b want 10", if1.req0_ready, if1.req1_ready); end
        @(negedge clk); // cycle 1
        if1.req0_valid = 1'b0;
        compared++; if (if1.alu_op !== 3'd2) begin mismatched++; $display("FAIL sim_alu_op0: got %0d want 2", if1.alu_op); end
        @(negedge clk); // cycle 2
        @(negedge clk); // cycle 3
        compared++; if (if1.rsp0_valid !== 1'b1 || if1.rsp0_result !== 16'h000C) begin mismatched++; $display("FAIL sim_rsp0: valid %b result %h want 1 000c", if1.rsp0_valid, if1.rsp0_result); end
        compared++; if (if1.req1_ready !== 1'b0) begin mismatched++; $display("FAIL sim_req1_stall: got %b want 0", if1.req1_ready); end
        @(negedge clk); // cycle 4, IDLE again
        compared++; if (if1.req1_ready !== 1'b1 || if1.rsp0_valid !== 1'b0) begin mismatched++; $display("FAIL sim_req1_ready: ready %b rsp0_valid %b want 1 0", if1.req1_ready, if1.rsp0_valid); end
        @(negedge clk); // cycle 5
        if1.req1_valid = 1'b0;
        compared++; if (if1.alu_op !== 3'd5 || if1.alu_a !== 16'h00F0) begin mismatched++; $display("FAIL sim_alu_op1: got %h/%h want 5/00f0", if1.alu_op, if1.alu_a); end
        @(negedge clk); // cycle 6
        @(negedge clk); // cycle 7
        compared++; if (if1.rsp1_valid !== 1'b1 || if1.rsp1_result !== 16'h0030 || if1.rsp0_valid !== 1'b0) begin mismatched++; $display("FAIL sim_rsp1: valid %b result %h rsp0_valid %b want 1 0030 0", if1.rsp1_valid, if1.rsp1_result, if1.rsp0_valid); end
        @(negedge clk); // cycle 8
        compared++; if (if1.rsp1_valid !== 1'b0) begin mismatched++; $display("FAIL sim_rsp1_done: got %b want 0", if1.rsp1_valid); end
    endtask

    task automatic test_contention();
        logic exp_g[6];
        logic got_g[6];
        int   got_c[6];
        int   n;
        int   cyc;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        n = 0;
        cyc = 0;
        if1.req0_valid = 1'b1; if1.req0_op = 3'd1; if1.req0_a = 16'h0001; if1.req0_b = 16'h0001;
        if1.req1_valid = 1'b1; if1.req1_op = 3'd2; if1.req1_a = 16'h0009; if1.req1_b = 16'h0001;
        if1.rsp0_ready = 1'b1; if1.rsp1_ready = 1'b1;
        while (n < 6 && cyc < 60) begin
            #1;
            compared++; if (if1.req0_ready === 1'b1 && if1.req1_ready === 1'b1) begin mismatched++; $display("FAIL cont_both_ready: cycle %0d got 11 want at most one", cyc); end
            if (if1.req0_ready === 1'b1 || if1.req1_ready === 1'b1) begin
                got_g[n] = if1.req1_ready;
                got_c[n] = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        if1.req0_valid = 1'b0;
        if1.req1_valid = 1'b0;
        compared++; if (n !== 6) begin mismatched++; $display("FAIL cont_grant_count: got %0d want 6", n); end
        for (int i = 0; i < n; i++) begin
            compared++; if (got_g[i] !== exp_g[i]) begin mismatched++; $display("FAIL cont_grant_%0d: got %0d want %0d", i, got_g[i], exp_g[i]); end
            if (i > 0) begin
                compared++; if (got_c[i] - got_c[i-1] !== 4) begin mismatched++; $display("FAIL cont_interval_%0d: got %0d want 4", i, got_c[i] - got_c[i-1]); end
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_backpressure();
        if1.req1_valid = 1'b1; if1.req1_op = 3'd3; if1.req1_a = 16'h1234; if1.req1_b = 16'h0F0F;
        if1.rsp1_ready = 1'b0; if1.rsp0_ready = 1'b0;
        @(negedge clk); // cycle 1: keep a competing request pending while busy
        if1.req1_valid = 1'b0;
        if1.req0_valid = 1'b1; if1.req0_op = 3'd1; if1.req0_a = 16'h0002; if1.req0_b = 16'h0002;
        @(negedge clk); // cycle 2
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); // cycles 3..7
            compared++; if (if1.rsp1_valid !== 1'b1 || if1.rsp1_result !== 16'h1D3B) begin mismatched++; $display("FAIL bp_hold_%0d: valid %b result %h want 1 1d3b", i, if1.rsp1_valid, if1.rsp1_result); end
            compared++; if (if1.req0_ready !== 1'b0 || if1.req1_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready_%0d: got %b%b want 00", i, if1.req0_ready, if1.req1_ready); end
        end
        @(negedge clk); // cycle 8
        compared++; if (if1.rsp1_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid_c8: got %b want 1", if1.rsp1_valid); end
        if1.rsp1_ready = 1'b1;
        @(negedge clk); // cycle 9
        compared++; if (if1.rsp1_valid !== 1'b0 || if1.rsp1_result !== 16'h1D3B) begin mismatched++; $display("FAIL bp_after_hs: valid %b result %h want 0 1d3b", if1.rsp1_valid, if1.rsp1_result); end
        compared++; if (if1.req0_ready !== 1'b1) begin mismatched++; $display("FAIL bp_idle_next: req0_ready %b want 1", if1.req0_ready); end
        if1.req0_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        if3.req0_valid = 1'b1; if3.req0_op = 3'd1; if3.req0_a = 16'h0100; if3.req0_b = 16'h0001; if3.rsp0_ready = 1'b1;
        @(negedge clk); // cycle 1
        if3.req0_valid = 1'b0;
        compared++; if (if3.alu_op !== 3'd1 || if3.alu_a !== 16'h0100) begin mismatched++; $display("FAIL rmid_issue: got %h/%h want 1/0100", if3.alu_op, if3.alu_a); end
        @(negedge clk); // cycle 2, in WAIT
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        compared++; if (if3.alu_op !== 3'd0 || if3.alu_a !== 16'h0000 || if3.alu_b !== 16'h0000) begin mismatched++; $display("FAIL rmid_alu_clear: got %h/%h/%h want 0/0000/0000", if3.alu_op, if3.alu_a, if3.alu_b); end
        compared++; if (if3.rsp0_valid !== 1'b0 || if3.rsp0_result !== 16'h0000) begin mismatched++; $display("FAIL rmid_rsp_clear: valid %b result %h want 0 0000", if3.rsp0_valid, if3.rsp0_result); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if3.rsp0_valid !== 1'b0 || if3.rsp1_valid !== 1'b0) pulses++;
        end
        compared++; if (pulses !== 0) begin mismatched++; $display("FAIL rmid_no_rsp: got %0d valid cycles want 0", pulses); end
        if3.req0_valid = 1'b1; if3.req0_op = 3'd2; if3.req0_a = 16'h0050; if3.req0_b = 16'h0010;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) if3.req0_valid = 1'b0;
            compared++; if (if3.rsp0_valid !== (c == 5)) begin mismatched++; $display("FAIL rmid_resubmit_c%0d: valid %b want %0d", c, if3.rsp0_valid, (c == 5)); end
            if (c == 5) begin
                compared++; if (if3.rsp0_result !== 16'h0040) begin mismatched++; $display("FAIL rmid_resubmit_result: got %h want 0040", if3.rsp0_result); end
            end
        end
    endtask

    task automatic test_latency_sweep();
        if0.req0_valid = 1'b1; if0.req0_op = 3'd1; if0.req0_a = 16'h0007; if0.req0_b = 16'h0009; if0.rsp0_ready = 1'b1;
        if7.req1_valid = 1'b1; if7.req1_op = 3'd2; if7.req1_a = 16'h0020; if7.req1_b = 16'h0005; if7.rsp1_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if0.req0_valid = 1'b0;
                if7.req1_valid = 1'b0;
            end
            compared++; if (if0.rsp0_valid !== (c == 2)) begin mismatched++; $display("FAIL lat0_valid_c%0d: got %b want %0d", c, if0.rsp0_valid, (c == 2)); end
            compared++; if (if7.rsp1_valid !== (c == 9)) begin mismatched++; $display("FAIL lat7_valid_c%0d: got %b want %0d", c, if7.rsp1_valid, (c == 9)); end
            if (c == 2) begin
                compared++; if (if0.rsp0_result !== 16'h0010) begin mismatched++; $display("FAIL lat0_result: got %h want 0010", if0.rsp0_result); end
            end
            if (c == 9) begin
                compared++; if (if7.rsp1_result !== 16'h001B) begin mismatched++; $display("FAIL lat7_result: got %h want 001b", if7.rsp1_result); end
            end
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        rst3 = 1'b1;
        init_inputs();
        test_reset();
        test_single_op();
        test_simultaneous();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_latency_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
